// File: rtl/dlsc_pcie_s6_inbound_completer_pkg.sv
// +--------------------------------------------------------------------------+
// | dlsc_pcie_s6_pkg: shared TLP, status, AXI response and FSM definitions   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package dlsc_pcie_s6_pkg;

  localparam logic [2:0] FMT_CPL    = 3'b000;
  localparam logic [2:0] FMT_CPLD   = 3'b010;
  localparam logic [4:0] TYPE_CPL   = 5'b01010;

  localparam logic [2:0] CPL_SC     = 3'b000;
  localparam logic [2:0] CPL_UR     = 3'b001;
  localparam logic [2:0] CPL_CA     = 3'b100;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_H0    = 3'd1,
    ST_H1    = 3'd2,
    ST_H2    = 3'd3,
    ST_DATA  = 3'd4,
    ST_DRAIN = 3'd5
  } cpl_state_t;

  // EXOKAY has no meaning for a read completion, so it is reported as abort.
  function automatic logic [2:0] resp_to_status(input logic [1:0] resp);
    case (resp)
      AXI_OKAY:   return CPL_SC;
      AXI_DECERR: return CPL_UR;
      default:    return CPL_CA;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dlsc_pcie_s6_inbound_completer_if.sv
// +--------------------------------------------------------------------------+
// | dlsc_pcie_s6_inbound_completer_if: requester, header, data and TX buses  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface dlsc_pcie_s6_inbound_completer_if;

  logic        req_ready;
  logic        req_valid;
  logic [15:0] req_id;
  logic [7:0]  req_tag;
  logic [2:0]  req_tc;
  logic [1:0]  req_attr;

  logic        cpl_h_ready;
  logic        cpl_h_valid;
  logic [6:0]  cpl_h_addr;
  logic [9:0]  cpl_h_len;
  logic [11:0] cpl_h_bytes;
  logic        cpl_h_last;
  logic [1:0]  cpl_h_resp;

  logic        cpl_d_ready;
  logic        cpl_d_valid;
  logic [31:0] cpl_d_data;
  logic        cpl_d_last;

  logic        tx_ready;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_last;

  modport slave (
    output req_ready, cpl_h_ready, cpl_d_ready, tx_valid, tx_data, tx_last,
    input  req_valid, req_id, req_tag, req_tc, req_attr,
    input  cpl_h_valid, cpl_h_addr, cpl_h_len, cpl_h_bytes, cpl_h_last, cpl_h_resp,
    input  cpl_d_valid, cpl_d_data, cpl_d_last, tx_ready
  );

  modport master (
    input  req_ready, cpl_h_ready, cpl_d_ready, tx_valid, tx_data, tx_last,
    output req_valid, req_id, req_tag, req_tc, req_attr,
    output cpl_h_valid, cpl_h_addr, cpl_h_len, cpl_h_bytes, cpl_h_last, cpl_h_resp,
    output cpl_d_valid, cpl_d_data, cpl_d_last, tx_ready
  );

endinterface

`default_nettype wire

// File: rtl/dlsc_pcie_s6_inbound_completer_hdr.sv
// +--------------------------------------------------------------------------+
// | dlsc_pcie_s6_inbound_completer_hdr: builds completion header DW0..DW2    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module dlsc_pcie_s6_inbound_completer_hdr
  import dlsc_pcie_s6_pkg::*;
(
  input  logic [15:0] cpl_id,
  input  logic [15:0] req_id,
  input  logic [7:0]  req_tag,
  input  logic [2:0]  req_tc,
  input  logic [1:0]  req_attr,
  input  logic [6:0]  addr,
  input  logic [9:0]  len,
  input  logic [11:0] bytes,
  input  logic [2:0]  status,
  output logic [31:0] dw0,
  output logic [31:0] dw1,
  output logic [31:0] dw2,
  output logic        is_cpld
);

  always_comb begin
    is_cpld = (status == CPL_SC);
    // fmt, type, R, TC, R, TD, EP, attr, AT, length
    dw0 = {is_cpld ? FMT_CPLD : FMT_CPL, TYPE_CPL, 1'b0, req_tc, 4'b0000,
           1'b0, 1'b0, req_attr, 2'b00, is_cpld ? len : 10'd0};
    dw1 = {cpl_id, status, 1'b0, bytes};
    dw2 = {req_id, req_tag, 1'b0, addr};
  end

endmodule

`default_nettype wire

// File: rtl/dlsc_pcie_s6_inbound_completer.sv
// +--------------------------------------------------------------------------+
// | dlsc_pcie_s6_inbound_completer: completion TLP generator (Spartan-6)     |
// | DLSC_PCIE_S6_INBOUND_COMPLETER_REGISTER_EN adds a TX register slice.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module dlsc_pcie_s6_inbound_completer
  import dlsc_pcie_s6_pkg::*;
#(
  parameter int unsigned CHECK_LEN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpl_id,
  dlsc_pcie_s6_inbound_completer_if.slave bus,
  output logic        err_len
);

  cpl_state_t  state, state_nxt;
  logic [6:0]  hdr_addr;
  logic [9:0]  hdr_len;
  logic [11:0] hdr_bytes;
  logic        hdr_last;
  logic [2:0]  hdr_status;
  logic        drop;

  logic        latch, drop_set, drop_clr, d_pop;
  logic        h_pop, r_pop, d_rdy;
  logic        core_valid, core_ready, core_last;
  logic [31:0] core_data;
  logic [31:0] dw0, dw1, dw2;
  logic        is_cpld;

  dlsc_pcie_s6_inbound_completer_hdr u_hdr (
    .cpl_id   (cpl_id),
    .req_id   (bus.req_id),
    .req_tag  (bus.req_tag),
    .req_tc   (bus.req_tc),
    .req_attr (bus.req_attr),
    .addr     (hdr_addr),
    .len      (hdr_len),
    .bytes    (hdr_bytes),
    .status   (hdr_status),
    .dw0      (dw0),
    .dw1      (dw1),
    .dw2      (dw2),
    .is_cpld  (is_cpld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      drop       <= 1'b0;
      hdr_addr   <= '0;
      hdr_len    <= '0;
      hdr_bytes  <= '0;
      hdr_last   <= 1'b0;
      hdr_status <= CPL_SC;
    end else begin
      state <= state_nxt;
      if (drop_set)      drop <= 1'b1;
      else if (drop_clr) drop <= 1'b0;
      if (latch) begin
        hdr_addr   <= bus.cpl_h_addr;
        hdr_len    <= bus.cpl_h_len;
        hdr_bytes  <= bus.cpl_h_bytes;
        hdr_last   <= bus.cpl_h_last;
        hdr_status <= resp_to_status(bus.cpl_h_resp);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    core_valid = 1'b0;
    core_data  = '0;
    core_last  = 1'b0;
    h_pop      = 1'b0;
    r_pop      = 1'b0;
    d_rdy      = 1'b0;
    d_pop      = 1'b0;
    latch      = 1'b0;
    drop_set   = 1'b0;
    drop_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cpl_h_valid && bus.req_valid) begin
          latch = 1'b1;
          // Remaining segments of a failed request are swallowed without a TLP.
          if (drop) begin
            h_pop     = 1'b1;
            r_pop     = bus.cpl_h_last;
            drop_clr  = bus.cpl_h_last;
            state_nxt = ST_DRAIN;
          end else begin
            state_nxt = ST_H0;
          end
        end
      end
      ST_H0: begin
        core_valid = 1'b1;
        core_data  = dw0;
        if (core_ready) state_nxt = ST_H1;
      end
      ST_H1: begin
        core_valid = 1'b1;
        core_data  = dw1;
        if (core_ready) state_nxt = ST_H2;
      end
      ST_H2: begin
        core_valid = 1'b1;
        core_data  = dw2;
        core_last  = !is_cpld;
        if (core_ready) begin
          h_pop     = 1'b1;
          r_pop     = hdr_last;
          drop_set  = !is_cpld && !hdr_last;
          state_nxt = is_cpld ? ST_DATA : ST_DRAIN;
        end
      end
      ST_DATA: begin
        core_valid = bus.cpl_d_valid;
        core_data  = bus.cpl_d_data;
        core_last  = bus.cpl_d_last;
        d_rdy      = core_ready;
        d_pop      = bus.cpl_d_valid && core_ready;
        if (d_pop && bus.cpl_d_last) state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        d_rdy = 1'b1;
        d_pop = bus.cpl_d_valid;
        if (d_pop && bus.cpl_d_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.req_ready   = r_pop;
  assign bus.cpl_h_ready = h_pop;
  assign bus.cpl_d_ready = d_rdy;

  generate
    if (CHECK_LEN != 0) begin : g_len_check
      logic [9:0] cnt;
      logic [9:0] cnt_inc;
      assign cnt_inc = cnt + 10'd1;
      // Wrapping 10-bit count makes a header length of 0 match 1024 DWs.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt     <= '0;
          err_len <= 1'b0;
        end else begin
          if (latch)      cnt <= '0;
          else if (d_pop) cnt <= cnt_inc;
          if (d_pop && (bus.cpl_d_last != (cnt_inc == hdr_len))) err_len <= 1'b1;
        end
      end
    end else begin : g_no_len_check
      assign err_len = 1'b0;
    end
  endgenerate

`ifdef DLSC_PCIE_S6_INBOUND_COMPLETER_REGISTER_EN
  logic        out_valid, out_last, skid_valid, skid_last;
  logic [31:0] out_data, skid_data;

  assign core_ready = !skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || bus.tx_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_last   <= skid_last;
        skid_valid <= 1'b0;
      end else begin
        out_valid  <= core_valid;
        out_data   <= core_data;
        out_last   <= core_last;
      end
    end else if (core_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= core_data;
      skid_last  <= core_last;
    end
  end

  assign bus.tx_valid = out_valid;
  assign bus.tx_data  = out_data;
  assign bus.tx_last  = out_last;
`else
  assign core_ready   = bus.tx_ready;
  assign bus.tx_valid = core_valid;
  assign bus.tx_data  = core_data;
  assign bus.tx_last  = core_last;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dlsc_pcie_s6_inbound_completer.sv
// +--------------------------------------------------------------------------+
// | tb_dlsc_pcie_s6_inbound_completer: scoreboard bench for the completer    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dlsc_pcie_s6_inbound_completer;

  typedef struct packed {
    logic [15:0] id;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [1:0]  attr;
  } req_t;

  typedef struct packed {
    logic [6:0]  addr;
    logic [9:0]  len;
    logic [11:0] bytes;
    logic        last;
    logic [1:0]  resp;
  } hdr_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } dw_t;

  localparam logic [15:0] CPL_ID = 16'hA5C3;
`ifdef DLSC_PCIE_S6_INBOUND_COMPLETER_REGISTER_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_len;

  dlsc_pcie_s6_inbound_completer_if bus ();

  dlsc_pcie_s6_inbound_completer #(.CHECK_LEN(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpl_id  (CPL_ID),
    .bus     (bus),
    .err_len (err_len)
  );

  always #5 clk = ~clk;

  req_t rq[$];
  hdr_t hq[$];
  dw_t  dq[$];
  dw_t  exp_q[$];

  int n_cmp = 0, n_fail = 0;
  int req_pops = 0, exp_pops = 0, beats = 0;
  bit gaps = 1'b1, rdy_rand = 1'b1;
  bit m_drop = 1'b0, m_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic issue_req(input req_t r);
    rq.push_back(r);
  endtask

  // Reference model: turns one header + its data into the expected TLP stream.
  task automatic issue_seg(input req_t r, input hdr_t h, input int ndw);
    dw_t w;
    logic [31:0] d[$];
    logic [2:0]  st;
    bit          is_d;
    hq.push_back(h);
    for (int i = 0; i < ndw; i++) begin
      w.data = $urandom;
      w.last = (i == ndw - 1);
      dq.push_back(w);
      d.push_back(w.data);
    end
    if ((ndw % 1024) != int'(h.len)) m_err = 1'b1;
    if (h.last) exp_pops++;
    st   = (h.resp == 2'b00) ? 3'b000 : (h.resp == 2'b11) ? 3'b001 : 3'b100;
    is_d = (st == 3'b000);
    if (m_drop) begin
      if (h.last) m_drop = 1'b0;
    end else begin
      w.data = (is_d ? 32'h4000_0000 : 32'h0) + (32'd10 << 24) + (32'(r.tc) << 20)
             + (32'(r.attr) << 12) + (is_d ? 32'(h.len) : 32'd0);
      w.last = 1'b0;
      exp_q.push_back(w);
      w.data = (32'(CPL_ID) << 16) + (32'(st) << 13) + 32'(h.bytes);
      exp_q.push_back(w);
      w.data = (32'(r.id) << 16) + (32'(r.tag) << 8) + 32'(h.addr);
      w.last = !is_d;
      exp_q.push_back(w);
      if (is_d) begin
        for (int i = 0; i < d.size(); i++) begin
          w.data = d[i];
          w.last = (i == d.size() - 1);
          exp_q.push_back(w);
        end
      end else if (!h.last) begin
        m_drop = 1'b1;
      end
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || hq.size() != 0 || dq.size() != 0 || rq.size() != 0)
           && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: %0d DWs still pending, required 0", name, exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic phase_check(input string name);
    check({name, "_req_pops"}, 64'(req_pops), 64'(exp_pops));
    check({name, "_err_len"}, 64'(err_len), 64'(m_err));
  endtask

  // Stream drivers: handshake decided at negedge, next item presented after posedge.
  initial begin : req_drv
    bit take;
    bus.req_valid = 1'b0;
    bus.req_id = '0; bus.req_tag = '0; bus.req_tc = '0; bus.req_attr = '0;
    forever begin
      @(negedge clk);
      take = bus.req_valid && bus.req_ready;
      @(posedge clk); #1;
      if (!rst_n) begin
        rq.delete();
        bus.req_valid = 1'b0;
      end else begin
        if (take && rq.size() > 0) begin
          rq.delete(0);
          bus.req_valid = 1'b0;
          req_pops++;
        end
        if (!bus.req_valid && rq.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
          bus.req_valid = 1'b1;
          bus.req_id    = rq[0].id;
          bus.req_tag   = rq[0].tag;
          bus.req_tc    = rq[0].tc;
          bus.req_attr  = rq[0].attr;
        end
      end
    end
  end

  initial begin : hdr_drv
    bit take;
    bus.cpl_h_valid = 1'b0;
    bus.cpl_h_addr = '0; bus.cpl_h_len = '0; bus.cpl_h_bytes = '0;
    bus.cpl_h_last = 1'b0; bus.cpl_h_resp = '0;
    forever begin
      @(negedge clk);
      take = bus.cpl_h_valid && bus.cpl_h_ready;
      @(posedge clk); #1;
      if (!rst_n) begin
        hq.delete();
        bus.cpl_h_valid = 1'b0;
      end else begin
        if (take && hq.size() > 0) begin
          hq.delete(0);
          bus.cpl_h_valid = 1'b0;
        end
        if (!bus.cpl_h_valid && hq.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
          bus.cpl_h_valid = 1'b1;
          bus.cpl_h_addr  = hq[0].addr;
          bus.cpl_h_len   = hq[0].len;
          bus.cpl_h_bytes = hq[0].bytes;
          bus.cpl_h_last  = hq[0].last;
          bus.cpl_h_resp  = hq[0].resp;
        end
      end
    end
  end

  initial begin : dat_drv
    bit take;
    bus.cpl_d_valid = 1'b0;
    bus.cpl_d_data = '0;
    bus.cpl_d_last = 1'b0;
    forever begin
      @(negedge clk);
      take = bus.cpl_d_valid && bus.cpl_d_ready;
      @(posedge clk); #1;
      if (!rst_n) begin
        dq.delete();
        bus.cpl_d_valid = 1'b0;
      end else begin
        if (take && dq.size() > 0) begin
          dq.delete(0);
          bus.cpl_d_valid = 1'b0;
        end
        if (!bus.cpl_d_valid && dq.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
          bus.cpl_d_valid = 1'b1;
          bus.cpl_d_data  = dq[0].data;
          bus.cpl_d_last  = dq[0].last;
        end
      end
    end
  end

  initial begin : rdy_drv
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    bit          pend;
    logic [31:0] pd;
    logic        pl;
    dw_t         e;
    pend = 1'b0;
    pd   = '0;
    pl   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        pend = 1'b0;
      end else begin
        if (pend)
          check("tx_hold", 64'({bus.tx_valid, bus.tx_last, bus.tx_data}), 64'({1'b1, pl, pd}));
        pend = bus.tx_valid && !bus.tx_ready;
        pd   = bus.tx_data;
        pl   = bus.tx_last;
        if (bus.tx_valid && bus.tx_ready) begin
          beats++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL tx_extra: got DW %h last %0b, expected no beat", bus.tx_data, bus.tx_last);
          end else begin
            e = exp_q[0];
            exp_q.delete(0);
            check("tx_dw", 64'({bus.tx_last, bus.tx_data}), 64'({e.last, e.data}));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    req_t r;
    hdr_t h;
    int   k, lat, segs_left, ns, pick, b0;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({bus.tx_valid, bus.tx_last, bus.cpl_h_ready, bus.cpl_d_ready, bus.req_ready, err_len, bus.tx_data}),
          64'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", 64'({bus.tx_valid, bus.cpl_h_ready, bus.req_ready, bus.tx_data}), 64'(0));

    // OKAY len 4, with DW0 latency measurement
    gaps = 1'b0; rdy_rand = 1'b0;
    r = '{id: 16'h1234, tag: 8'h56, tc: 3'd0, attr: 2'd0};
    issue_req(r);
    issue_seg(r, '{addr: 7'h10, len: 10'd4, bytes: 12'd16, last: 1'b1, resp: 2'b00}, 4);
    k = 0;
    while (!(bus.cpl_h_valid && bus.req_valid) && k < 20) begin @(negedge clk); k++; end
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.tx_valid && lat < 10);
    check("dw0_latency", 64'(lat), 64'(EXP_LAT));
    check("dw0_value", 64'(bus.tx_data), 64'(32'h4A00_0004));
    wait_done("okay4", 200);
    phase_check("okay4");

    // DECERR len 2
    gaps = 1'b1; rdy_rand = 1'b1;
    r = '{id: 16'hBEEF, tag: 8'h07, tc: 3'd5, attr: 2'd2};
    issue_req(r);
    issue_seg(r, '{addr: 7'h04, len: 10'd2, bytes: 12'd8, last: 1'b1, resp: 2'b11}, 2);
    wait_done("decerr", 200);
    phase_check("decerr");

    // SLVERR on first of three segments
    r = '{id: 16'h0A0B, tag: 8'h99, tc: 3'd1, attr: 2'd1};
    issue_req(r);
    issue_seg(r, '{addr: 7'h00, len: 10'd3, bytes: 12'd36, last: 1'b0, resp: 2'b10}, 3);
    issue_seg(r, '{addr: 7'h0C, len: 10'd3, bytes: 12'd24, last: 1'b0, resp: 2'b00}, 3);
    issue_seg(r, '{addr: 7'h18, len: 10'd3, bytes: 12'd12, last: 1'b1, resp: 2'b00}, 3);
    wait_done("slverr", 400);
    phase_check("slverr");

    // Length field 0 means 1024 DWs
    r = '{id: 16'h4242, tag: 8'h01, tc: 3'd7, attr: 2'd3};
    issue_req(r);
    issue_seg(r, '{addr: 7'h00, len: 10'd0, bytes: 12'd0, last: 1'b1, resp: 2'b00}, 1024);
    wait_done("len1024", 20000);
    phase_check("len1024");

    // Random mixed completions under backpressure
    segs_left = 20;
    while (segs_left > 0) begin
      r.id = 16'($urandom); r.tag = 8'($urandom); r.tc = 3'($urandom); r.attr = 2'($urandom);
      issue_req(r);
      ns = $urandom_range(1, 3);
      if (ns > segs_left) ns = segs_left;
      for (int s = 0; s < ns; s++) begin
        h.addr  = 7'($urandom);
        h.len   = 10'($urandom_range(1, 6));
        h.bytes = 12'($urandom);
        h.last  = (s == ns - 1);
        pick    = $urandom_range(0, 9);
        h.resp  = (pick < 6) ? 2'b00 : (pick == 6) ? 2'b01 : (pick == 7) ? 2'b10 : 2'b11;
        issue_seg(r, h, int'(h.len));
      end
      segs_left -= ns;
    end
    wait_done("random", 5000);
    phase_check("random");

    // Early cpl_d_last: err_len must latch and stay
    r = '{id: 16'h7777, tag: 8'h3C, tc: 3'd2, attr: 2'd0};
    issue_req(r);
    issue_seg(r, '{addr: 7'h20, len: 10'd4, bytes: 12'd16, last: 1'b1, resp: 2'b00}, 3);
    wait_done("short", 300);
    phase_check("short");
    r = '{id: 16'h8888, tag: 8'h3D, tc: 3'd3, attr: 2'd1};
    issue_req(r);
    issue_seg(r, '{addr: 7'h24, len: 10'd2, bytes: 12'd8, last: 1'b1, resp: 2'b00}, 2);
    wait_done("after_short", 300);
    phase_check("after_short");

    // Reset in the middle of the data phase
    gaps = 1'b0; rdy_rand = 1'b0;
    b0 = beats;
    r = '{id: 16'h5151, tag: 8'h11, tc: 3'd0, attr: 2'd0};
    issue_req(r);
    issue_seg(r, '{addr: 7'h08, len: 10'd6, bytes: 12'd24, last: 1'b1, resp: 2'b00}, 6);
    k = 0;
    while (beats < b0 + 4 && k < 100) begin @(negedge clk); k++; end
    @(posedge clk); #2;
    check("pre_reset_valid", 64'(bus.tx_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(bus.tx_valid), 64'(0));
    repeat (3) @(negedge clk);
    m_drop = 1'b0;
    m_err  = 1'b0;
    check("reset_err_len", 64'(err_len), 64'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    gaps = 1'b1; rdy_rand = 1'b1;
    r = '{id: 16'h6262, tag: 8'h22, tc: 3'd4, attr: 2'd2};
    issue_req(r);
    issue_seg(r, '{addr: 7'h30, len: 10'd3, bytes: 12'd12, last: 1'b1, resp: 2'b00}, 3);
    wait_done("post_reset", 300);
    phase_check("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
